bus_arbiter_2x1: RTL and testbench

BUS_ARBITER_2X1 -- requirements
Module: bus_arbiter_2x1

---
 rtl/bus_arb_pkg.sv | 13 +
 rtl/bus_arbiter_2x1_rr_pick.sv | 17 +
 rtl/bus_arbiter_2x1.sv | 73 +++++++
 tb/tb_bus_arbiter_2x1.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-requester bus arbiter: FSM encoding and
// default widths.
package bus_arb_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic {
      IDLE = 1'b0,
      FULL = 1'b1
   } arb_state_t;

endpackage

// File: rtl/bus_arbiter_2x1_rr_pick.sv
// Combinational round-robin pick between two requesters. last_grant uses the
// owner encoding (0 = requester 1, 1 = requester 2).
module rr_pick_2 (
   input  logic req_1,
   input  logic req_2,
   input  logic last_grant,
   output logic gnt_1,
   output logic gnt_2
);

   // On a tie, the requester that was not served last wins.
   always_comb begin
      gnt_1 = req_1 && (!req_2 || last_grant);
      gnt_2 = req_2 && (!req_1 || !last_grant);
   end

endmodule

// File: rtl/bus_arbiter_2x1.sv
// Two-to-one bus arbiter with a single registered output slot, round-robin
// tie breaking and a completed-transfer counter.
module bus_arbiter_2x1
   import bus_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_1,
   input  logic [DATA_W-1:0] Data_in_1,
   input  logic              req_2,
   input  logic [DATA_W-1:0] Data_in_2,
   output logic              gnt_1,
   output logic              gnt_2,
   output logic [DATA_W-1:0] DOut,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              owner,
   output logic [CNT_W-1:0]  xfer_count
);

   arb_state_t state;
   logic       last_grant;
   logic       pick_1;
   logic       pick_2;
   logic       cap_opp;
   logic       done;

   rr_pick_2 u_pick (
      .req_1      (req_1),
      .req_2      (req_2),
      .last_grant (last_grant),
      .gnt_1      (pick_1),
      .gnt_2      (pick_2)
   );

   // The slot can take a new word when empty or when it drains this cycle;
   // grants are forced low while reset is held.
   always_comb begin
      cap_opp = (state == IDLE) || dout_ready;
      done    = (state == FULL) && dout_ready;
      gnt_1   = !rst && cap_opp && pick_1;
      gnt_2   = !rst && cap_opp && pick_2;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         DOut       <= '0;
         dout_valid <= 1'b0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         xfer_count <= '0;
      end else begin
         if (done) begin
            xfer_count <= xfer_count + CNT_W'(1);
         end
         if (gnt_1 || gnt_2) begin
            DOut       <= gnt_2 ? Data_in_2 : Data_in_1;
            owner      <= gnt_2;
            last_grant <= gnt_2;
            dout_valid <= 1'b1;
            state      <= FULL;
         end else if (done) begin
            dout_valid <= 1'b0;
            state      <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_bus_arbiter_2x1.sv
// Directed and randomized checks of bus_arbiter_2x1 against a cycle-level
// behavioural model of the output slot, grant rules and transfer counter.
module tb_bus_arbiter_2x1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_1 = 1'b0;
   logic [31:0] Data_in_1 = '0;
   logic        req_2 = 1'b0;
   logic [31:0] Data_in_2 = '0;
   logic        gnt_1;
   logic        gnt_2;
   logic [31:0] DOut;
   logic        dout_valid;
   logic        dout_ready = 1'b0;
   logic        owner;
   logic [15:0] xfer_count;

   int n_assert = 0;
   int n_fail   = 0;

   // Model: slot contents, who was served last (1 or 2), transfers completed.
   bit          m_valid;
   logic [31:0] m_data;
   bit          m_owner;
   int          m_last;
   int unsigned m_count;
   int          last_w;
   logic        s_g1;
   logic        s_g2;

   bus_arbiter_2x1 dut (
      .clk        (clk),
      .rst        (rst),
      .req_1      (req_1),
      .Data_in_1  (Data_in_1),
      .req_2      (req_2),
      .Data_in_2  (Data_in_2),
      .gnt_1      (gnt_1),
      .gnt_2      (gnt_2),
      .DOut       (DOut),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .owner      (owner),
      .xfer_count (xfer_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0;
      m_data  = '0;
      m_owner = 0;
      m_last  = 2;
      m_count = 0;
   endtask

   // Which requester the rules say must be granted now (0 = none).
   function automatic int exp_winner();
      if (m_valid && !dout_ready) return 0;
      if (req_1 && req_2) return (m_last == 1) ? 2 : 1;
      if (req_1) return 1;
      if (req_2) return 2;
      return 0;
   endfunction

   task automatic step(input bit chk_on);
      int w;
      #1;
      w    = exp_winner();
      s_g1 = gnt_1;
      s_g2 = gnt_2;
      if (chk_on) begin
         check("gnt_1", gnt_1, (w == 1));
         check("gnt_2", gnt_2, (w == 2));
         check("gnt_excl", gnt_1 & gnt_2, 0);
      end
      @(posedge clk);
      if (m_valid && dout_ready) m_count = (m_count + 1) % 65536;
      if (w != 0) begin
         m_valid = 1;
         m_data  = (w == 1) ? Data_in_1 : Data_in_2;
         m_owner = (w == 2);
         m_last  = w;
      end else if (m_valid && dout_ready) begin
         m_valid = 0;
      end
      last_w = w;
      #1;
      if (chk_on) begin
         check("dout_valid", dout_valid, m_valid);
         check("DOut", DOut, m_data);
         check("owner", owner, m_owner);
         check("xfer_count", xfer_count, m_count);
      end
   endtask

   task automatic do_reset();
      req_1 = 0; req_2 = 0; dout_ready = 0;
      rst = 1;
      #1;
      req_1 = 1; req_2 = 1;
      #1;
      check("rst_gnt_1", gnt_1, 0);
      check("rst_gnt_2", gnt_2, 0);
      check("rst_valid", dout_valid, 0);
      check("rst_dout", DOut, 0);
      check("rst_owner", owner, 0);
      check("rst_count", xfer_count, 0);
      @(posedge clk);
      #1;
      rst = 0; req_1 = 0; req_2 = 0;
      model_reset();
   endtask

   initial begin
      logic [31:0] held;
      int guard;
      model_reset();

      // Single request right after reset release.
      do_reset();
      req_1 = 1; Data_in_1 = 32'hAAAA0001; dout_ready = 1;
      step(1);
      check("first_gnt_1", s_g1, 1);
      req_1 = 0;
      check("first_dout", DOut, 32'hAAAA0001);
      check("first_owner", owner, 0);
      check("first_valid", dout_valid, 1);
      step(1);
      check("first_count", xfer_count, 1);

      // Both requesting continuously: strict alternation starting with 1.
      do_reset();
      dout_ready = 1; req_1 = 1; req_2 = 1;
      Data_in_1 = 32'h1000_0000; Data_in_2 = 32'h2000_0000;
      for (int i = 0; i < 4; i++) begin
         step(1);
         check("rr_order_g1", s_g1, (i % 2 == 0));
         check("rr_order_g2", s_g2, (i % 2 == 1));
         check("rr_dout", DOut, (i % 2 == 0) ? 32'h1000_0000 + i : 32'h2000_0000 + i);
         Data_in_1 = 32'h1000_0000 + i + 1;
         Data_in_2 = 32'h2000_0000 + i + 1;
      end
      req_1 = 0; req_2 = 0;
      step(1);

      // Stall with a pending competitor, then release.
      do_reset();
      req_2 = 1; Data_in_2 = 32'h12345678; dout_ready = 0;
      step(1);
      req_2 = 0; req_1 = 1; Data_in_1 = 32'hCAFE0001;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("stall_gnt_1", s_g1, 0);
         check("stall_dout", DOut, 32'h12345678);
      end
      dout_ready = 1;
      step(1);
      check("release_gnt_1", s_g1, 1);
      req_1 = 0;

      // Request withdrawn while the slot is stalled.
      dout_ready = 0;
      held = DOut;
      req_2 = 1; Data_in_2 = 32'hDEAD0002;
      step(1);
      check("pulse_gnt_2", s_g2, 0);
      req_2 = 0;
      step(1);
      check("pulse_dout", DOut, held);
      dout_ready = 1;
      step(1);
      check("pulse_drained_valid", dout_valid, 0);

      // Asynchronous reset while the slot is full.
      do_reset();
      dout_ready = 1; req_1 = 1; Data_in_1 = 32'h0BAD0001;
      step(1);
      Data_in_1 = 32'h0BAD0002;
      step(1);
      req_1 = 0;
      rst = 1;
      #2;
      check("async_valid", dout_valid, 0);
      check("async_dout", DOut, 0);
      check("async_count", xfer_count, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 0;
      req_1 = 1; req_2 = 1; Data_in_1 = 32'h5555_0001; Data_in_2 = 32'h6666_0002;
      step(1);
      check("post_rst_tie_g1", s_g1, 1);
      check("post_rst_tie_g2", s_g2, 0);
      req_1 = 0; req_2 = 0;
      step(1);

      // Randomized traffic with withdrawals and back-pressure.
      for (int i = 0; i < 400; i++) begin
         if (last_w == 1) req_1 = 0;
         if (last_w == 2) req_2 = 0;
         if (req_1 && $urandom_range(9) == 0) req_1 = 0;
         else if (!req_1 && $urandom_range(1) == 1) begin
            req_1 = 1; Data_in_1 = $urandom;
         end
         if (req_2 && $urandom_range(9) == 0) req_2 = 0;
         else if (!req_2 && $urandom_range(1) == 1) begin
            req_2 = 1; Data_in_2 = $urandom;
         end
         dout_ready = ($urandom_range(9) < 7);
         step(1);
      end

      // Counter wrap: stream transfers until the count reaches 0xFFFE.
      do_reset();
      req_1 = 1; dout_ready = 1; Data_in_1 = 32'h7777_0000;
      guard = 0;
      while (m_count != 32'hFFFE && guard < 70000) begin
         step(0);
         guard++;
      end
      check("wrap_reach", guard < 70000, 1);
      check("wrap_fffe", xfer_count, 16'hFFFE);
      step(1);
      check("wrap_ffff", xfer_count, 16'hFFFF);
      step(1);
      check("wrap_zero", xfer_count, 16'h0000);
      req_1 = 0;
      step(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
